// File: rtl/pipe_pkg.sv
// Shared pipeline encodings: forwarding selects, decoder pcsource values and the
// hazard sequencer state type.
package pipe_pkg;

    localparam logic [1:0] FWD_RF     = 2'b00;
    localparam logic [1:0] FWD_EXALU  = 2'b01;
    localparam logic [1:0] FWD_MEMALU = 2'b10;
    localparam logic [1:0] FWD_MEMLD  = 2'b11;

    localparam logic [1:0] PCS_SEQ = 2'b00;
    localparam logic [1:0] PCS_BR  = 2'b01;
    localparam logic [1:0] PCS_J   = 2'b10;
    localparam logic [1:0] PCS_ILL = 2'b11;

    typedef enum logic [1:0] {
        HZ_RUN        = 2'd0,
        HZ_LOAD_STALL = 2'd1,
        HZ_MEM_WAIT   = 2'd2
    } hz_state_t;

endpackage

// File: rtl/fwd_sel.sv
// Operand forwarding select for one ID source register against the EX/MEM
// destination tags; the youngest producer (EX) wins.
module fwd_sel
    import pipe_pkg::*;
(
    input  logic [4:0] src_rn,
    input  logic       ex_wreg,
    input  logic       ex_sld,
    input  logic [4:0] ex_rn,
    input  logic       mem_wreg,
    input  logic       mem_sld,
    input  logic [4:0] mem_rn,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        // r0 is hardwired zero, so it never takes a forwarded value.
        if (src_rn != 5'd0) begin
            if (ex_wreg && !ex_sld && (ex_rn == src_rn))
                sel = FWD_EXALU;
            else if (mem_wreg && (mem_rn == src_rn))
                sel = mem_sld ? FWD_MEMLD : FWD_MEMALU;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipe: forwarding selects, load-use bubbles,
// branch squash, data-memory freeze, plus sticky error flags and perf counters.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int MEM_TMO = 15
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [1:0]       id_pcsource,
    input  logic             ex_wreg,
    input  logic             ex_sld,
    input  logic [4:0]       ex_rn,
    input  logic             mem_wreg,
    input  logic             mem_sld,
    input  logic [4:0]       mem_rn,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             id_bubble,
    output logic             if_flush,
    output logic             pipe_freeze,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             illegal_op,
    output logic             mem_tmo_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int         NUM_OPS = 2;
    localparam logic [7:0] TMO     = 8'(MEM_TMO);

    logic [NUM_OPS-1:0][4:0] src_rn;
    logic [NUM_OPS-1:0][1:0] fwd;

    assign src_rn = {id_rt, id_rs};

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
        fwd_sel u_fwd_sel (
            .src_rn   (src_rn[g]),
            .ex_wreg  (ex_wreg),
            .ex_sld   (ex_sld),
            .ex_rn    (ex_rn),
            .mem_wreg (mem_wreg),
            .mem_sld  (mem_sld),
            .mem_rn   (mem_rn),
            .sel      (fwd[g])
        );
    end

    hz_state_t  state, state_nx;
    logic [7:0] wait_cnt, wait_nx;
    logic       load_use, mem_busy;
    logic       pc_we_c, bubble_c, flush_c, freeze_c, ill_set, tmo_set;

    assign load_use = ex_wreg && ex_sld && (ex_rn != 5'd0) &&
                      ((id_use_rs && (ex_rn == id_rs)) || (id_use_rt && (ex_rn == id_rt)));
    assign mem_busy = mem_access && !dmem_ready;

    always_comb begin
        state_nx = state;
        wait_nx  = wait_cnt;
        pc_we_c  = 1'b1;
        bubble_c = 1'b0;
        flush_c  = 1'b0;
        freeze_c = 1'b0;
        ill_set  = 1'b0;
        tmo_set  = 1'b0;
        case (state)
            HZ_MEM_WAIT: begin
                if (dmem_ready) begin
                    state_nx = HZ_RUN;
                end else begin
                    pc_we_c  = 1'b0;
                    freeze_c = 1'b1;
                    wait_nx  = (wait_cnt == 8'hff) ? wait_cnt : wait_cnt + 8'd1;
                    tmo_set  = (wait_nx >= TMO);
                end
            end
            // RUN and LOAD_STALL decode identically; only the stall entry differs.
            default: begin
                if (mem_busy) begin
                    pc_we_c  = 1'b0;
                    freeze_c = 1'b1;
                    wait_nx  = 8'd0;
                    state_nx = HZ_MEM_WAIT;
                end else if (load_use) begin
                    pc_we_c  = 1'b0;
                    bubble_c = 1'b1;
                    state_nx = HZ_LOAD_STALL;
                end else begin
                    flush_c  = (id_pcsource == PCS_BR) || (id_pcsource == PCS_J);
                    ill_set  = (id_pcsource == PCS_ILL);
                    state_nx = HZ_RUN;
                end
            end
        endcase
    end

    assign pc_we       = !resetn || pc_we_c;
    assign id_bubble   = resetn && bubble_c;
    assign if_flush    = resetn && flush_c;
    assign pipe_freeze = resetn && freeze_c;
    assign fwda        = resetn ? fwd[0] : FWD_RF;
    assign fwdb        = resetn ? fwd[1] : FWD_RF;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= HZ_RUN;
            wait_cnt    <= 8'd0;
            illegal_op  <= 1'b0;
            mem_tmo_err <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
            if (ill_set) illegal_op  <= 1'b1;
            if (tmo_set) mem_tmo_err <= 1'b1;
            if (!pc_we_c && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_c && (flush_cnt != '1))  flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule
